// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq.
//   in_valid / in_ready / bin             : producer side, binary value in
//   out_valid / out_ready / bcd / overflow : consumer side, BCD digits out
// Modports:
//   slave  - the converter
//   master - whoever drives the converter (score counter / bench)
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport slave (
    input  in_valid,
    input  bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd,
    output overflow
  );

  modport master (
    output in_valid,
    output bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd,
    input  overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A value accepted at edge k is presented on bcd/overflow with out_valid high
// after edge k+BIN_W. Results are held until out_ready; a new value may be
// accepted on the same cycle the previous result is taken.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset
//   bus_io  - bin_to_bcd_seq_if.slave handshake bundle
//
// Optional feature: define BIN_TO_BCD_BLANK_EN to replace leading zero digits
// with 4'hF (blank code for the digit decoders). Digit 0 is never blanked and
// nothing is blanked when overflow is reported.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  bin_to_bcd_seq_if.slave       bus_io
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   work_q,  work_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CntW-1:0]   cnt_q,   cnt_d;
  logic [BcdW-1:0]   bcd_q,   bcd_d;
  logic              ovf_q,   ovf_d;

  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   work_step;
  logic              carry_out;
  logic              in_ready;

`ifdef BIN_TO_BCD_BLANK_EN
  // Blank every digit above the most significant non-zero one.
  function automatic logic [BcdW-1:0] blank_digits(input logic [BcdW-1:0] v,
                                                   input logic            ovf);
    logic [BcdW-1:0] r;
    logic            seen;
    r    = v;
    seen = ovf;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (!seen && (v[4*k +: 4] == 4'h0)) begin
        r[4*k +: 4] = 4'hF;
      end else begin
        seen = 1'b1;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [BcdW-1:0] blank_digits(input logic [BcdW-1:0] v,
                                                   input logic            ovf);
    logic unused_ovf;
    unused_ovf = ovf;
    return v;
  endfunction
`endif

  // One double-dabble step: add 3 to digits >= 5, then shift {bcd, bin} left.
  // The bit leaving the top digit means the value no longer fits in DIGITS.
  always_comb begin
    adj = work_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
    work_step = {adj[BcdW-2:0], shift_q[BIN_W-1]};
    carry_out = adj[BcdW-1];
  end

  assign in_ready = (state_q == StIdle) ||
                    ((state_q == StDone) && bus_io.out_ready);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    work_d    = work_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          shift_d   = bus_io.bin;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        work_d    = work_step;
        shift_d   = shift_q << 1;
        ovf_acc_d = ovf_acc_q | carry_out;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StDone;
          ovf_d   = ovf_acc_q | carry_out;
          bcd_d   = blank_digits(work_step, ovf_acc_q | carry_out);
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          if (bus_io.in_valid) begin
            shift_d   = bus_io.bin;
            work_d    = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = '0;
            state_d   = StConv;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.bcd       = bcd_q;
  assign bus_io.overflow  = ovf_q;

endmodule
